rx_dec_parser: RTL

RX_DEC_PARSER -- requirements
Module: rx_dec_parser

---
 rtl/rx_dec_parser.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_dec_parser.sv
// -----------------------------------------------------------------------------
// rx_dec_parser
//
// Pulls ASCII bytes from a first-word-fall-through RX FIFO and parses lines of
// the form "A B OP\r". Each field is 1-3 decimal digits with a value of 0-255.
// Fields are separated by one or more spaces. A good line updates
// OP_A/OP_B/OP_CODE and pulses VALID. A malformed line is discarded up to its
// CR and pulses ERROR.
//
// Optional feature: define ECHO_EN to copy every popped byte into a TX FIFO.
// In that build, popping is held off while tx_full is high. Without ECHO_EN,
// WR_ECHO and echo_data are tied low and tx_full is ignored.
//
// Ports
//   CLK         clock, rising edge
//   RESET       asynchronous active-low reset
//   fifo_empty  RX FIFO empty flag
//   rx_data     RX FIFO head byte, valid while fifo_empty=0
//   tx_full     TX FIFO full flag (ECHO_EN only)
//   RD_FIFO     RX FIFO pop strobe, combinational
//   WR_ECHO     TX FIFO write strobe (ECHO_EN only)
//   echo_data   byte written to the TX FIFO (ECHO_EN only)
//   OP_A/OP_B/OP_CODE  parsed fields, held until the next VALID
//   VALID       one-cycle pulse: new fields presented
//   ERROR       one-cycle pulse: malformed line dropped
//   STATE       current FSM state, for debug
// -----------------------------------------------------------------------------
module rx_dec_parser (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fifo_empty,
  input  logic [7:0] rx_data,
  input  logic       tx_full,
  output logic       RD_FIFO,
  output logic       WR_ECHO,
  output logic [7:0] echo_data,
  output logic [7:0] OP_A,
  output logic [7:0] OP_B,
  output logic [7:0] OP_CODE,
  output logic       VALID,
  output logic       ERROR,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    DONE   = 3'd2,
    DRAIN  = 3'd3
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;

  state_t      state_reg, state_next;
  logic [7:0]  ch_reg, ch_next;
  logic [7:0]  acc_reg, acc_next;
  logic [1:0]  ndig_reg, ndig_next;
  logic [1:0]  fidx_reg, fidx_next;
  logic [7:0]  field_reg [3];
  logic [2:0]  field_we;
  logic [7:0]  op_a_reg, op_b_reg, op_code_reg;
  logic        load_op;
  logic        valid_reg, valid_next;
  logic        error_reg, error_next;
  logic        pop_ok;
  logic        is_digit;
  logic [11:0] acc_wide;

  // For ASCII '0'-'9', the low nibble is the digit value.
  assign is_digit = (ch_reg >= 8'h30) && (ch_reg <= 8'h39);
  // The widest possible result is 255*10+9, so 12 bits is enough to detect overflow.
  assign acc_wide = ({4'd0, acc_reg} * 12'd10) + {8'd0, ch_reg[3:0]};

`ifdef ECHO_EN
  assign pop_ok    = RESET && !fifo_empty && !tx_full;
  assign WR_ECHO   = RD_FIFO;
  assign echo_data = rx_data;
`else
  logic unused_tx_full;
  assign unused_tx_full = tx_full;
  assign pop_ok    = RESET && !fifo_empty;
  assign WR_ECHO   = 1'b0;
  assign echo_data = 8'h00;
`endif

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    acc_next   = acc_reg;
    ndig_next  = ndig_reg;
    fidx_next  = fidx_reg;
    field_we   = 3'b000;
    load_op    = 1'b0;
    valid_next = 1'b0;
    error_next = 1'b0;
    RD_FIFO    = 1'b0;

    case (state_reg)
      FETCH: begin
        if (pop_ok) begin
          RD_FIFO    = 1'b1;
          ch_next    = rx_data;
          state_next = DECODE;
        end
      end

      DECODE: begin
        state_next = FETCH;
        if (is_digit) begin
          if (fidx_reg == 2'd3 || ndig_reg == 2'd3 || acc_wide > 12'd255) begin
            state_next = DRAIN;
          end else begin
            acc_next  = acc_wide[7:0];
            ndig_next = ndig_reg + 2'd1;
          end
        end else if (ch_reg == CH_SPACE) begin
          // Repeated spaces are ignored. A space that ends a field commits it.
          if (ndig_reg != 2'd0) begin
            field_we  = 3'b001 << fidx_reg;
            fidx_next = fidx_reg + 2'd1;
            acc_next  = 8'd0;
            ndig_next = 2'd0;
          end
        end else if (ch_reg == CH_CR) begin
          if ((fidx_reg == 2'd2 && ndig_reg != 2'd0) ||
              (fidx_reg == 2'd3 && ndig_reg == 2'd0)) begin
            if (ndig_reg != 2'd0) field_we = 3'b100;
            // Load the outputs now so they line up with VALID in DONE.
            load_op    = 1'b1;
            valid_next = 1'b1;
            state_next = DONE;
          end else if (!(fidx_reg == 2'd0 && ndig_reg == 2'd0)) begin
            error_next = 1'b1;
            acc_next   = 8'd0;
            ndig_next  = 2'd0;
            fidx_next  = 2'd0;
          end
        end else begin
          state_next = DRAIN;
        end
      end

      DONE: begin
        acc_next   = 8'd0;
        ndig_next  = 2'd0;
        fidx_next  = 2'd0;
        state_next = FETCH;
      end

      DRAIN: begin
        if (pop_ok) begin
          RD_FIFO = 1'b1;
          if (rx_data == CH_CR) begin
            error_next = 1'b1;
            acc_next   = 8'd0;
            ndig_next  = 2'd0;
            fidx_next  = 2'd0;
            state_next = FETCH;
          end
        end
      end

      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= FETCH;
      ch_reg      <= 8'd0;
      acc_reg     <= 8'd0;
      ndig_reg    <= 2'd0;
      fidx_reg    <= 2'd0;
      op_a_reg    <= 8'd0;
      op_b_reg    <= 8'd0;
      op_code_reg <= 8'd0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      for (int i = 0; i < 3; i++) field_reg[i] <= 8'd0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      acc_reg   <= acc_next;
      ndig_reg  <= ndig_next;
      fidx_reg  <= fidx_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
      for (int i = 0; i < 3; i++) begin
        if (field_we[i]) field_reg[i] <= acc_reg;
      end
      if (load_op) begin
        op_a_reg    <= field_reg[0];
        op_b_reg    <= field_reg[1];
        // A line that ends in a digit still holds its last field in acc.
        op_code_reg <= (ndig_reg != 2'd0) ? acc_reg : field_reg[2];
      end
    end
  end

  assign OP_A    = op_a_reg;
  assign OP_B    = op_b_reg;
  assign OP_CODE = op_code_reg;
  assign VALID   = valid_reg;
  assign ERROR   = error_reg;
  assign STATE   = state_reg;

endmodule
